// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings and
// a helper that extracts one channel's 2-bit mode field from the packed bus.
package edge_det_pkg;

    // Per-channel mode encodings; bit0 enables rising, bit1 enables falling.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Widest channel count the mode helper can address.
    localparam int unsigned MAX_CH     = 64;
    localparam int unsigned MODE_VEC_W = 2 * MAX_CH;

    // Return bits [2*ch+1:2*ch] of a zero-extended packed mode bus.
    function automatic logic [1:0] mode_slice(input logic [MODE_VEC_W-1:0] mode_vec,
                                              input int unsigned         ch);
        return mode_vec[2*ch +: 2];
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: input synchroniser, consecutive-sample glitch
// filter and registered rising/falling pulse generation.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3,
    parameter int unsigned CNT_W       = $clog2(FILT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in,
    input  logic [1:0] mode,
    output logic       level,
    output logic       rising,
    output logic       falling,
    output logic       rise_next,
    output logic       fall_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rising_q, falling_q;
    logic                   rise_en, fall_en;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise_en = |(mode & MODE_RISE);
    assign fall_en = |(mode & MODE_FALL);

    // Synchroniser shift chain; bit 0 captures the raw pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // Filter next state: level flips only after FILT_CYCLES consecutive differing samples.
    always_comb begin
        level_d   = level_q;
        cnt_d     = cnt_q;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        rise_next = ~level_q & level_d & rise_en;
        fall_next = level_q & ~level_d & fall_en;
    end

    // Filter state and registered edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q   <= 1'b0;
            cnt_q     <= '0;
            rising_q  <= 1'b0;
            falling_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            rising_q  <= rise_next;
            falling_q <= fall_next;
        end
    end

    assign level   = level_q;
    assign rising  = rising_q;
    assign falling = falling_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector top: per-channel sync/filter/pulse instances plus
// sticky write-1-to-clear status flags and a registered combined interrupt.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   in,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clear,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   rising,
    output logic [N_CH-1:0]   falling,
    output logic [N_CH-1:0]   status,
    output logic              irq
);

    // Derived filter counter width; not meant to be overridden.
    localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);

    logic [N_CH-1:0] rise_next, fall_next;
    logic [N_CH-1:0] status_q, status_d;
    logic            irq_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYCLES(FILT_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .in       (in[i]),
            .mode     (mode_slice(MODE_VEC_W'(mode), i)),
            .level    (level[i]),
            .rising   (rising[i]),
            .falling  (falling[i]),
            .rise_next(rise_next[i]),
            .fall_next(fall_next[i])
        );
    end

    // Sticky status: a new pulse wins over a simultaneous clear.
    always_comb begin
        status_d = (status_q & ~clear) | rise_next | fall_next;
    end

    // Status and irq registers; irq tracks status with identical timing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= |status_d;
        end
    end

    assign status = status_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector (default parameters).
// The reference model treats the filter as a sliding window over delayed
// input samples: the level flips when the last FILT_CYCLES synced samples
// all differ from it.
module tb_multi_edge_detector;

    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYCLES = 3;

    logic              clk;
    logic              reset_n;
    logic [N_CH-1:0]   in;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   clear;
    logic [N_CH-1:0]   level;
    logic [N_CH-1:0]   rising;
    logic [N_CH-1:0]   falling;
    logic [N_CH-1:0]   status;
    logic              irq;

    int checks = 0;
    int errors = 0;

    multi_edge_detector #(
        .N_CH       (N_CH),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .in     (in),
        .mode   (mode),
        .clear  (clear),
        .level  (level),
        .rising (rising),
        .falling(falling),
        .status (status),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N_CH-1:0] samples[$];
    logic [N_CH-1:0] m_level  = '0;
    logic [N_CH-1:0] m_rise   = '0;
    logic [N_CH-1:0] m_fall   = '0;
    logic [N_CH-1:0] m_status = '0;
    logic            m_irq    = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic [N_CH-1:0] nl, r, f, st;
        int              n, idx;
        logic            all_diff, sv;
        if (!reset_n) begin
            samples.delete();
            m_level  <= '0;
            m_rise   <= '0;
            m_fall   <= '0;
            m_status <= '0;
            m_irq    <= 1'b0;
        end else begin
            n  = samples.size();
            nl = m_level;
            for (int ch = 0; ch < N_CH; ch++) begin
                all_diff = 1'b1;
                for (int k = 0; k < FILT_CYCLES; k++) begin
                    idx = n - SYNC_STAGES - k;
                    sv  = (idx >= 0) ? samples[idx][ch] : 1'b0;
                    if (sv == m_level[ch]) all_diff = 1'b0;
                end
                if (all_diff) nl[ch] = ~m_level[ch];
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                r[ch] = ~m_level[ch] & nl[ch] & mode[2*ch];
                f[ch] = m_level[ch] & ~nl[ch] & mode[2*ch+1];
            end
            st = (m_status & ~clear) | r | f;
            m_level  <= nl;
            m_rise   <= r;
            m_fall   <= f;
            m_status <= st;
            m_irq    <= |st;
            samples.push_back(in);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("cyc_level",   32'(level),   32'(m_level));
        chk("cyc_rising",  32'(rising),  32'(m_rise));
        chk("cyc_falling", 32'(falling), 32'(m_fall));
        chk("cyc_status",  32'(status),  32'(m_status));
        chk("cyc_irq",     32'(irq),     32'(m_irq));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int ch, output int rc, output int fc);
        rc = 0;
        fc = 0;
        repeat (n) begin
            step();
            rc += int'(rising[ch]);
            fc += int'(falling[ch]);
        end
    endtask

    task automatic run_any(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            step();
            if ((|rising) || (|falling)) pulses++;
        end
    endtask

    int rc, fc, pc;

    initial begin
        reset_n = 1'b0;
        in      = '1;
        mode    = 8'($urandom);
        clear   = '0;

        // 1: reset holds all outputs low even with inputs high.
        repeat (4) @(posedge clk);
        #1;
        chk("rst_level",  32'(level),   32'h0);
        chk("rst_rising", 32'(rising),  32'h0);
        chk("rst_fall",   32'(falling), 32'h0);
        chk("rst_status", 32'(status),  32'h0);
        chk("rst_irq",    32'(irq),     32'h0);
        @(negedge clk);
        in      = '0;
        reset_n = 1'b1;
        run_any(20, pc);
        chk("rst_no_pulses", 32'(pc), 32'h0);
        chk("rst_level_after", 32'(level), 32'h0);

        // 2: rising on ch0, level and pulse after edge 5.
        mode  = 8'b11_01_11_01;
        in[0] = 1'b1;
        repeat (4) step();
        chk("rise_lat_level_e4", 32'(level[0]), 32'h0);
        step();
        chk("rise_level_e5",  32'(level[0]),  32'h1);
        chk("rise_pulse_e5",  32'(rising[0]), 32'h1);
        chk("rise_status_e5", 32'(status[0]), 32'h1);
        chk("rise_irq_e5",    32'(irq),       32'h1);
        step();
        chk("rise_pulse_e6",  32'(rising[0]), 32'h0);
        chk("rise_level_e6",  32'(level[0]),  32'h1);

        // 3: glitch of 2 cycles filtered out, 3 cycles accepted.
        in[1] = 1'b1;
        step();
        step();
        in[1] = 1'b0;
        run(12, 1, rc, fc);
        chk("glitch2_rise",  32'(rc),       32'h0);
        chk("glitch2_fall",  32'(fc),       32'h0);
        chk("glitch2_level", 32'(level[1]), 32'h0);
        in[1] = 1'b1;
        repeat (3) step();
        in[1] = 1'b0;
        run(15, 1, rc, fc);
        chk("glitch3_rise", 32'(rc), 32'h1);
        chk("glitch3_fall", 32'(fc), 32'h1);

        // 4: mode masking on ch2.
        in[2] = 1'b1;
        run(10, 2, rc, fc);
        chk("mask_rise_rc", 32'(rc), 32'h1);
        chk("mask_rise_fc", 32'(fc), 32'h0);
        chk("mask_rise_level", 32'(level[2]), 32'h1);
        in[2] = 1'b0;
        run(10, 2, rc, fc);
        chk("mask_fall_rc", 32'(rc), 32'h0);
        chk("mask_fall_fc", 32'(fc), 32'h0);
        chk("mask_fall_level", 32'(level[2]), 32'h0);
        mode[5:4] = 2'b10;
        run(10, 2, rc, fc);
        chk("mask_switch_pulses", 32'(rc + fc), 32'h0);
        in[2] = 1'b1;
        run(10, 2, rc, fc);
        chk("mask_fallmode_rise", 32'(rc + fc), 32'h0);
        chk("mask_fallmode_level", 32'(level[2]), 32'h1);
        in[2] = 1'b0;
        run(10, 2, rc, fc);
        chk("mask_fallmode_fall", 32'(fc), 32'h1);
        chk("mask_fallmode_norise", 32'(rc), 32'h0);

        // 5: status set beats clear; clear on the following cycle drops it.
        clear = '1;
        step();
        clear = '0;
        chk("clr_all_status", 32'(status), 32'h0);
        chk("clr_all_irq",    32'(irq),    32'h0);
        in[3] = 1'b1;
        repeat (4) step();
        clear[3] = 1'b1;
        step();
        chk("setwins_rise",   32'(rising[3]), 32'h1);
        chk("setwins_status", 32'(status[3]), 32'h1);
        chk("setwins_irq",    32'(irq),       32'h1);
        step();
        clear[3] = 1'b0;
        chk("clr_status", 32'(status), 32'h0);
        chk("clr_irq",    32'(irq),    32'h0);

        // 6: async reset mid-filter discards partial history.
        in = '0;
        repeat (15) step();
        in[0] = 1'b1;
        repeat (3) step();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_level",   32'(level),   32'h0);
        chk("arst_rising",  32'(rising),  32'h0);
        chk("arst_falling", 32'(falling), 32'h0);
        chk("arst_status",  32'(status),  32'h0);
        chk("arst_irq",     32'(irq),     32'h0);
        in = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run_any(20, pc);
        chk("arst_no_pulses", 32'(pc), 32'h0);
        chk("arst_level_after", 32'(level), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
